// File: rtl/pll_tune_scheduler.sv
// Arbitrates PLL retune requests from two requesters, drives the reconfig
// wrapper handshake, and supervises lock acquisition with bounded PLL-reset retries.
module pll_tune_scheduler #(
   parameter int unsigned ACK_TIMEOUT   = 64,
   parameter int unsigned LOCK_TIMEOUT  = 50000,
   parameter int unsigned SETTLE_CYCLES = 256,
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned MAX_RETRY     = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_a,
   input  logic [2:0] m_a,
   input  logic [3:0] n_a,
   input  logic       req_b,
   input  logic [2:0] m_b,
   input  logic [3:0] n_b,
   output logic       gnt_a,
   output logic       gnt_b,
   output logic [2:0] cfg_m,
   output logic [3:0] cfg_n,
   output logic       cfg_strobe,
   input  logic       cfg_busy,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       done,
   output logic       err,
   output logic       ready,
   output logic       lock_lost
);

   localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WAIT_LOCK, RST_PLL
   } state_t;

   state_t             state, state_d;
   logic               lock_s1, lock_sync;
   logic               prefer_b, prefer_b_d;
   logic               skip_pend, skip_d;
   logic               gnt_a_d, gnt_b_d, strobe_d, pll_reset_d;
   logic               done_d, err_d, ready_d, lock_lost_d;
   logic [2:0]         cfg_m_d;
   logic [3:0]         cfg_n_d;
   logic [ACK_W-1:0]   ack_cnt, ack_d;
   logic [15:0]        lock_cnt, lock_d;
   logic [SET_W-1:0]   settle_cnt, settle_d;
   logic [RST_W-1:0]   rst_cnt, rst_d;
   logic [RTY_W-1:0]   retry_cnt, retry_d;
   logic               pick_b;
   logic [2:0]         req_m;
   logic [3:0]         req_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         lock_s1    <= 1'b0;
         lock_sync  <= 1'b0;
         prefer_b   <= 1'b0;
         skip_pend  <= 1'b0;
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         cfg_m      <= '0;
         cfg_n      <= '0;
         cfg_strobe <= 1'b0;
         pll_reset  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         ready      <= 1'b0;
         lock_lost  <= 1'b0;
         ack_cnt    <= '0;
         lock_cnt   <= '0;
         settle_cnt <= '0;
         rst_cnt    <= '0;
         retry_cnt  <= '0;
      end else begin
         state      <= state_d;
         lock_s1    <= pll_lock;
         lock_sync  <= lock_s1;
         prefer_b   <= prefer_b_d;
         skip_pend  <= skip_d;
         gnt_a      <= gnt_a_d;
         gnt_b      <= gnt_b_d;
         cfg_m      <= cfg_m_d;
         cfg_n      <= cfg_n_d;
         cfg_strobe <= strobe_d;
         pll_reset  <= pll_reset_d;
         done       <= done_d;
         err        <= err_d;
         ready      <= ready_d;
         lock_lost  <= lock_lost_d;
         ack_cnt    <= ack_d;
         lock_cnt   <= lock_d;
         settle_cnt <= settle_d;
         rst_cnt    <= rst_d;
         retry_cnt  <= retry_d;
      end
   end

   assign pick_b = req_b && (!req_a || prefer_b);
   assign req_m  = pick_b ? m_b : m_a;
   assign req_n  = pick_b ? n_b : n_a;

   always_comb begin
      state_d     = state;
      prefer_b_d  = prefer_b;
      skip_d      = 1'b0;
      gnt_a_d     = 1'b0;
      gnt_b_d     = 1'b0;
      cfg_m_d     = cfg_m;
      cfg_n_d     = cfg_n;
      strobe_d    = 1'b0;
      pll_reset_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      ready_d     = ready;
      lock_lost_d = lock_lost;
      ack_d       = ack_cnt;
      lock_d      = lock_cnt;
      settle_d    = settle_cnt;
      rst_d       = rst_cnt;
      retry_d     = retry_cnt;

      unique case (state)
         IDLE: begin
            if (skip_pend) done_d = 1'b1;
            if (ready && !lock_sync) begin
               ready_d     = 1'b0;
               lock_lost_d = 1'b1;
            end
            // Requests stay asserted through the gnt cycle, so no grant while a gnt is out.
            if ((req_a || req_b) && !cfg_busy && !gnt_a && !gnt_b) begin
               gnt_a_d    = !pick_b;
               gnt_b_d    = pick_b;
               prefer_b_d = !pick_b;
               cfg_m_d    = req_m;
               cfg_n_d    = req_n;
               if (ready && lock_sync && req_m == cfg_m && req_n == cfg_n) begin
                  skip_d = 1'b1;
               end else begin
                  ready_d = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            strobe_d = 1'b1;
            ack_d    = '0;
            state_d  = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (cfg_busy) begin
               state_d = WAIT_DONE;
            end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               ack_d = ack_cnt + ACK_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!cfg_busy) begin
               lock_d   = '0;
               settle_d = '0;
               state_d  = WAIT_LOCK;
            end
         end
         WAIT_LOCK: begin
            if (lock_sync && settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
               done_d      = 1'b1;
               ready_d     = 1'b1;
               lock_lost_d = 1'b0;
               retry_d     = '0;
               state_d     = IDLE;
            end else begin
               settle_d = lock_sync ? settle_cnt + SET_W'(1) : '0;
               if (lock_cnt == 16'(LOCK_TIMEOUT - 1)) begin
                  if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                     retry_d     = retry_cnt + RTY_W'(1);
                     pll_reset_d = 1'b1;
                     rst_d       = '0;
                     state_d     = RST_PLL;
                  end else begin
                     err_d   = 1'b1;
                     retry_d = '0;
                     state_d = IDLE;
                  end
               end else begin
                  lock_d = lock_cnt + 16'd1;
               end
            end
         end
         RST_PLL: begin
            if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
               lock_d   = '0;
               settle_d = '0;
               state_d  = WAIT_LOCK;
            end else begin
               pll_reset_d = 1'b1;
               rst_d       = rst_cnt + RST_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pll_tune_scheduler.sv
// Directed bench for pll_tune_scheduler: arbitration, skip, ack/lock timeouts,
// PLL reset retries, lock loss and mid-transaction reset.
module tb_pll_tune_scheduler;

   localparam int unsigned LOCK_T = 300;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_a, req_b;
   logic [2:0] m_a, m_b;
   logic [3:0] n_a, n_b;
   logic       gnt_a, gnt_b;
   logic [2:0] cfg_m;
   logic [3:0] cfg_n;
   logic       cfg_strobe, cfg_busy, pll_lock, pll_reset;
   logic       done, err, ready, lock_lost;

   int errors = 0;
   int checks = 0;
   int n_strobe = 0, n_done = 0, n_err = 0;
   bit wrap_ack = 1'b1;

   always #5 clk = ~clk;

   // Lock timeout shortened so three full timeouts fit a short run.
   pll_tune_scheduler #(
      .ACK_TIMEOUT(64), .LOCK_TIMEOUT(LOCK_T), .SETTLE_CYCLES(256),
      .RST_CYCLES(16), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_a(req_a), .m_a(m_a), .n_a(n_a),
      .req_b(req_b), .m_b(m_b), .n_b(n_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .cfg_m(cfg_m), .cfg_n(cfg_n),
      .cfg_strobe(cfg_strobe), .cfg_busy(cfg_busy), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .done(done), .err(err), .ready(ready),
      .lock_lost(lock_lost)
   );

   // Reconfig wrapper: busy for 10 cycles after each strobe when acking.
   initial begin : wrapper_model
      cfg_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (cfg_strobe && wrap_ack) begin
            cfg_busy = 1'b1;
            repeat (10) @(negedge clk);
            cfg_busy = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (cfg_strobe) n_strobe++;
      if (done) n_done++;
      if (err) n_err++;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sel(input int unsigned code);
      case (code)
         0: return gnt_a;
         1: return gnt_b;
         2: return cfg_strobe;
         3: return done;
         default: return err;
      endcase
   endfunction

   task automatic wait_for(input int unsigned code, input int unsigned budget,
                           input string tag, output int unsigned cyc);
      logic found;
      found = 1'b0;
      cyc   = 0;
      while (cyc < budget && !found) begin
         @(negedge clk);
         cyc++;
         found = sel(code);
      end
      check(tag, found, 1);
   endtask

   initial begin : stimulus
      int unsigned cyc;
      int s0, d0, e0, idx, ndone, pulses, hi, lo, gap1, gap_end;
      int widths[2];
      logic [3:0] order;
      bit prev, saw_err, saw_done;

      reset_n = 1'b0; pll_lock = 1'b1;
      req_a = 1'b0; m_a = '0; n_a = '0;
      req_b = 1'b0; m_b = '0; n_b = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {gnt_a, gnt_b, cfg_strobe, pll_reset, done, err, ready, lock_lost}, 0);
      check("reset_cfg", {cfg_m, cfg_n}, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic tune by A
      m_a = 3'd3; n_a = 4'd5; req_a = 1'b1;
      wait_for(0, 20, "a_gnt_seen", cyc);
      check("a_gnt_latency", cyc, 1);
      check("a_cfg", {cfg_m, cfg_n}, {3'd3, 4'd5});
      req_a = 1'b0;
      @(negedge clk);
      check("a_strobe", cfg_strobe, 1);
      // 10 busy cycles + WAIT_DONE exit + 256 settle cycles
      wait_for(3, 1000, "a_done_seen", cyc);
      check("a_done_latency", cyc, 267);
      check("a_ready", ready, 1);
      check("a_strobe_count", n_strobe, 1);

      // Skip: B asks for the already-locked configuration
      @(negedge clk);
      s0 = n_strobe;
      m_b = 3'd3; n_b = 4'd5; req_b = 1'b1;
      @(negedge clk);
      check("skip_gnt_b", gnt_b, 1);
      check("skip_no_early_done", done, 0);
      req_b = 1'b0;
      @(negedge clk);
      check("skip_done", done, 1);
      repeat (3) @(negedge clk);
      check("skip_no_strobe", n_strobe, s0);
      check("skip_ready", ready, 1);

      // Both requesters held: round-robin starting with A
      e0 = n_err;
      m_a = 3'd1; n_a = 4'd2; m_b = 3'd6; n_b = 4'd9;
      req_a = 1'b1; req_b = 1'b1;
      idx = 0; ndone = 0; order = '0;
      for (int i = 0; i < 3000 && ndone < 4; i++) begin
         @(negedge clk);
         if (gnt_a || gnt_b) begin
            if (idx < 4) order[idx] = gnt_b;
            idx++;
         end
         if (done) ndone++;
      end
      req_a = 1'b0; req_b = 1'b0;
      check("rr_grant_count", idx, 4);
      check("rr_order", order, 4'b1010);
      check("rr_dones", ndone, 4);
      check("rr_no_err", n_err, e0);

      // Lock loss while idle
      @(negedge clk);
      pll_lock = 1'b0;
      repeat (4) @(negedge clk);
      check("loss_ready", ready, 0);
      check("loss_flag", lock_lost, 1);
      s0 = n_strobe;
      pll_lock = 1'b1;
      repeat (4) @(negedge clk);
      check("loss_sticky", lock_lost, 1);
      check("loss_no_retune", n_strobe, s0);
      // Same m/n as cfg, but ready is low so it must go through the PLL
      m_a = 3'd6; n_a = 4'd9; req_a = 1'b1;
      wait_for(0, 20, "relock_gnt", cyc);
      req_a = 1'b0;
      wait_for(3, 1000, "relock_done", cyc);
      check("relock_strobe", n_strobe - s0, 1);
      check("relock_lost_clear", lock_lost, 0);
      check("relock_ready", ready, 1);

      // Ack timeout
      wrap_ack = 1'b0;
      d0 = n_done;
      m_b = 3'd2; n_b = 4'd2; req_b = 1'b1;
      wait_for(1, 20, "ack_gnt", cyc);
      req_b = 1'b0;
      wait_for(2, 5, "ack_strobe", cyc);
      check("ack_strobe_latency", cyc, 1);
      wait_for(4, 200, "ack_err_seen", cyc);
      check("ack_err_latency", cyc, 64);
      check("ack_no_done", n_done, d0);
      check("ack_ready", ready, 0);
      @(negedge clk);
      check("ack_err_one_cycle", err, 0);
      wrap_ack = 1'b1;

      // Lock never arrives: two PLL resets, then err
      pll_lock = 1'b0;
      m_a = 3'd4; n_a = 4'd3; req_a = 1'b1;
      wait_for(0, 20, "lf_gnt_after_ack_err", cyc);
      req_a = 1'b0;
      pulses = 0; hi = 0; lo = 0; gap1 = -1; gap_end = -1;
      widths[0] = 0; widths[1] = 0;
      prev = 1'b0; saw_err = 1'b0; saw_done = 1'b0;
      for (int i = 0; i < 3000 && !saw_err; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
         if (err) begin
            saw_err = 1'b1;
            if (pulses == 2) gap_end = lo;
         end else if (pll_reset) begin
            if (!prev && pulses == 1) gap1 = lo;
            hi++;
         end else begin
            if (prev) begin
               if (pulses < 2) widths[pulses] = hi;
               pulses++;
               hi = 0;
               lo = 0;
            end
            lo++;
         end
         prev = pll_reset;
      end
      check("lf_err_seen", saw_err, 1);
      check("lf_no_done", saw_done, 0);
      check("lf_pulses", pulses, 2);
      check("lf_width0", widths[0], 16);
      check("lf_width1", widths[1], 16);
      check("lf_gap_between", gap1, LOCK_T);
      check("lf_gap_to_err", gap_end, LOCK_T);
      check("lf_ready", ready, 0);

      // Reset mid WAIT_LOCK, after a grant to A
      pll_lock = 1'b1;
      m_a = 3'd5; n_a = 4'd6; req_a = 1'b1;
      wait_for(0, 20, "mr_gnt", cyc);
      req_a = 1'b0;
      wait_for(2, 5, "mr_strobe", cyc);
      repeat (30) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mr_outputs", {gnt_a, gnt_b, cfg_strobe, pll_reset, done, err, ready, lock_lost}, 0);
      check("mr_cfg", {cfg_m, cfg_n}, 0);
      d0 = n_done; e0 = n_err;
      repeat (400) @(negedge clk);
      check("mr_no_done", n_done, d0);
      check("mr_no_err", n_err, e0);
      // Arbitration pointer back to A; m/n match reset cfg but must still issue
      m_a = 3'd0; n_a = 4'd0; m_b = 3'd1; n_b = 4'd1;
      req_a = 1'b1; req_b = 1'b1;
      @(negedge clk);
      check("mr_pref_a", {gnt_a, gnt_b}, 2'b10);
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      check("mr_no_skip_strobe", cfg_strobe, 1);
      wait_for(3, 1000, "mr_done", cyc);
      check("mr_ready", ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_tune_scheduler.md
PLL_TUNE_SCHEDULER -- requirements
Module: pll_tune_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ACK_TIMEOUT, 64: max cycles from cfg_strobe until cfg_busy rises.
- LOCK_TIMEOUT, 50000: max cycles in WAIT_LOCK per attempt; 16-bit counter.
- SETTLE_CYCLES, 256: consecutive pll_lock-high cycles required to declare lock.
- RST_CYCLES, 16: pll_reset pulse width.
- MAX_RETRY, 2: PLL reset retries after a lock timeout.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset_n, in, 1: synchronous, active-low reset.
- req_a, in, 1: tune request, requester A (host); level, held until gnt_a.
- m_a, in, 3: M select for A.
- n_a, in, 4: N select for A.
- req_b, in, 1: tune request, requester B (sweep engine); level, held until gnt_b.
- m_b, in, 3: M select for B.
- n_b, in, 4: N select for B.
- gnt_a, out, 1: one-cycle accept pulse to A.
- gnt_b, out, 1: one-cycle accept pulse to B.
- cfg_m, out, 3: M select to the reconfig wrapper.
- cfg_n, out, 4: N select to the reconfig wrapper.
- cfg_strobe, out, 1: one-cycle start pulse to the wrapper.
- cfg_busy, in, 1: wrapper reconfiguration in progress.
- pll_lock, in, 1: PLL locked, asynchronous to clk.
- pll_reset, out, 1: PLL reset, active high.
- done, out, 1: one-cycle pulse, tune completed and locked.
- err, out, 1: one-cycle pulse, tune failed.
- ready, out, 1: high in IDLE with a valid, locked configuration.
- lock_lost, out, 1: sticky, lock dropped while idle.

Function
REQ-003 pll_lock SHALL be synchronised through two flops before any use; all timing below refers to the synchronised value.
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WAIT_LOCK, RST_PLL.
REQ-005 In IDLE with any request pending and cfg_busy low, the FSM SHALL grant one requester, latch its m/n into cfg_m/cfg_n, and pulse the matching gnt in the same cycle.
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last. After reset, A is preferred.
REQ-007 If the granted m/n equal the current cfg_m/cfg_n and ready is high, the FSM SHALL skip the PLL: done pulses the cycle after gnt, and the FSM stays in IDLE with no cfg_strobe.
REQ-008 ISSUE SHALL assert cfg_strobe for exactly one cycle, one cycle after gnt, then enter WAIT_ACK.
REQ-009 WAIT_ACK SHALL move to WAIT_DONE when cfg_busy is high. After ACK_TIMEOUT cycles without that, it SHALL pulse err and return to IDLE.
REQ-010 WAIT_DONE SHALL move to WAIT_LOCK on the first cycle cfg_busy is low, clearing the settle and lock timers. There is no timeout in WAIT_DONE.
REQ-011 WAIT_LOCK SHALL count consecutive lock-high cycles; any low cycle clears the count.
REQ-012 When the count reaches SETTLE_CYCLES, the FSM SHALL pulse done, set ready, clear lock_lost and the retry count, and return to IDLE.
REQ-013 On LOCK_TIMEOUT in WAIT_LOCK:
- if retries < MAX_RETRY: increment retries and enter RST_PLL;
- otherwise: pulse err, leave ready low, clear retries, return to IDLE.
REQ-014 RST_PLL SHALL hold pll_reset high for exactly RST_CYCLES cycles, then re-enter WAIT_LOCK with timers cleared.
REQ-015 ready SHALL fall on the gnt cycle of any non-skipped tune and stay low until done.
REQ-016 In IDLE with ready high, a lock low sample SHALL clear ready and set lock_lost. The block SHALL NOT retune autonomously.
REQ-017 Requests arriving in any state other than IDLE SHALL remain pending and SHALL NOT be granted until the FSM returns to IDLE.
REQ-018 done and err SHALL never assert in the same cycle; each transaction SHALL end in exactly one done or one err.

Reset
REQ-019 While reset_n is sampled low, the block SHALL:
- enter IDLE;
- clear all counters, the retry count and the arbitration pointer (A preferred);
- drive cfg_m=0, cfg_n=0 and all single-bit outputs low, including pll_reset and ready.
REQ-020 Reset asserted mid-transaction SHALL abort it with no done or err pulse; the next request after release SHALL always go through ISSUE (no skip).

Verification
REQ-021 A: req_a with m=3, n=5; the model raises cfg_busy for 10 cycles and lock is held high. Required: gnt_a; cfg_strobe exactly 1 cycle later with cfg_m=3, cfg_n=5; done after 256 lock cycles; ready=1.
REQ-022 Simultaneous: req_a and req_b held continuously, each transaction succeeds. Required grant order A, B, A, B, with no back-to-back grants to the same requester.
REQ-023 Skip: after a locked tune to m=3, n=5, req_b with m=3, n=5. Required: gnt_b, then done next cycle, no cfg_strobe, ready stays 1.
REQ-024 Lock failure: pll_lock held low. Required: two RST_PLL pulses of 16 cycles each, then err after the third 50000-cycle timeout; ready=0.
REQ-025 Ack timeout: cfg_busy never rises. Required: err 64 cycles after cfg_strobe, FSM back in IDLE.
REQ-026 Reset and lock loss:
- reset_n low for 1 cycle during WAIT_LOCK: all outputs 0, no done/err;
- lock dropped while idle and locked: ready=0, lock_lost=1.
